idex_pipe_reg: RTL and testbench
================================

# idex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage MIPS datapath, between decode (register file, sign extender, control unit) and execute (ALU, ALU-source mux, destination mux).

- Captures control and datapath fields every clock.
- Adds asynchronous reset, stall (hold), flush (bubble insertion) and a valid bit.
- Registers the rs, rt and rd fields independently.
- Provides a combinational load-use hazard flag for the fetch/decode stall logic.

## Interface
Parameters:
- DATA_W, 32, width of pcsumain, data1, data2, signextender
- REGADDR_W, 5, width of rs/rt/rd register-address fields
- ALUOP_W, 3, width of aluop

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- stall_in  in  1  hold all registered outputs
- flush_in  in  1  load a bubble
- valid_in  in  1  ID stage holds a real instruction
- regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in, alusrc_in, regdst_in  in  1 each  control from control unit
- aluop_in  in  ALUOP_W  ALU operation class
- pcsumain_in, data1_in, data2_in, signextender_in  in  DATA_W each  PC+4, rs data, rt data, sign-extended immediate
- rs_in, rt_in, rd_in  in  REGADDR_W each  instruction fields [25:21], [20:16], [15:11]
- regwrite_out … regdst_out, aluop_out, pcsumain_out, data1_out, data2_out, signextender_out, rs_out, rt_out, rd_out  out  same widths  registered copies
- valid_out  out  1  EX stage holds a real instruction
- load_use_hazard_out  out  1  combinational, EX load writes a register read by ID
- bubble_cnt_out, stall_cnt_out  out  32 each  present only with IDEX_PERF_CNT_EN

## Operation
- Priority per rising edge: rst > flush_in > stall_in > normal load.
- rst asserted, asynchronously:
  - All outputs go to 0, including aluop_out, datapath fields, register fields and valid_out.
  - Counters also go to 0.
- flush_in=1:
  - regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out and valid_out load 0.
  - aluop_out, alusrc_out, regdst_out, the datapath fields and rs/rt/rd_out hold their previous values.
  - This applies even when stall_in=1.
- stall_in=1 with flush_in=0: every register holds.
- Normal load: every output loads its _in counterpart; valid_out loads valid_in.
- valid_in=0 on a normal load: the five side-effect controls (regwrite, memtoreg, memwrite, memread, branch) are forced to 0, as in a flush. The remaining fields load normally.
- load_use_hazard_out = valid_out & memread_out & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
  - Purely combinational from the current registers and the ID-stage inputs.
  - Unaffected by stall_in and flush_in.
- No arithmetic in the datapath; fields pass unmodified at full declared width.

## Timing
- Latency: 1 cycle, input at edge N appears at outputs after edge N.
- Stall: outputs frozen for every cycle stall_in=1 is sampled; release resumes loading at the next edge.
- Reset deassertion: first load on the first rising edge after rst falls.
- Reset mid-stall or mid-flush: reset wins immediately, without waiting for an edge.
- load_use_hazard_out valid in the same cycle as its inputs. The external stall loop is expected to drive stall of PC/IF-ID and flush_in of this block in that cycle, so exactly one bubble is inserted.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - bubble_cnt_out increments on each edge where a bubble is loaded (flush_in=1, or a normal load with valid_in=0).
  - stall_cnt_out increments on each edge with stall_in=1 and flush_in=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset: drive all inputs to 1s with rst=1, release, hold inputs → all outputs 0 during reset, and equal the inputs one edge after release; valid_out=1.
- Pipeline: stream 4 instructions with pcsumain=0x4,0x8,0xC,0x10 → each appears one edge later with the matching data1/data2/rt/rd; rt_out and rd_out are distinct (e.g. 5'd9, 5'd17).
- Stall: stall_in=1 for 3 cycles while inputs change → outputs frozen at the pre-stall values; the next input loads on the first edge after release.
- Flush during stall:
  - Setup: register holds regwrite=1, memwrite=1, data1=0xDEADBEEF; then stall_in=1 and flush_in=1.
  - Expected: controls and valid_out go to 0; data1_out stays 0xDEADBEEF.
- Load-use:
  - Setup: EX holds lw with rt_out=8, memread_out=1, valid_out=1.
  - Drive rs_in=8 → load_use_hazard_out=1 in the same cycle.
  - Drive rs_in=rt_in=3 → 0.
  - With rt_out=0 → 0.
- Counters (IDEX_PERF_CNT_EN): 2 flushes, 3 stalls and 1 load with valid_in=0 → bubble_cnt_out=3, stall_cnt_out=3. Async reset mid-sequence clears both counters immediately.

Source files
------------

// File: rtl/idex_if.sv
// ID/EX pipeline register bundle: decode-side inputs, execute-side outputs, load-use flag.
// Counter outputs exist only when IDEX_PERF_CNT_EN is defined.
interface idex_if #(
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int ALUOP_W   = 3
);
   logic                 stall_in, flush_in, valid_in;
   logic                 regwrite_in, memtoreg_in, memwrite_in, memread_in;
   logic                 branch_in, alusrc_in, regdst_in;
   logic [ALUOP_W-1:0]   aluop_in;
   logic [DATA_W-1:0]    pcsumain_in, data1_in, data2_in, signextender_in;
   logic [REGADDR_W-1:0] rs_in, rt_in, rd_in;

   logic                 regwrite_out, memtoreg_out, memwrite_out, memread_out;
   logic                 branch_out, alusrc_out, regdst_out;
   logic [ALUOP_W-1:0]   aluop_out;
   logic [DATA_W-1:0]    pcsumain_out, data1_out, data2_out, signextender_out;
   logic [REGADDR_W-1:0] rs_out, rt_out, rd_out;
   logic                 valid_out;
   logic                 load_use_hazard_out;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0]          bubble_cnt_out, stall_cnt_out;

   modport master (
      output stall_in, flush_in, valid_in, regwrite_in, memtoreg_in, memwrite_in, memread_in,
             branch_in, alusrc_in, regdst_in, aluop_in, pcsumain_in, data1_in, data2_in,
             signextender_in, rs_in, rt_in, rd_in,
      input  regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out, alusrc_out,
             regdst_out, aluop_out, pcsumain_out, data1_out, data2_out, signextender_out,
             rs_out, rt_out, rd_out, valid_out, load_use_hazard_out, bubble_cnt_out, stall_cnt_out
   );
   modport slave (
      input  stall_in, flush_in, valid_in, regwrite_in, memtoreg_in, memwrite_in, memread_in,
             branch_in, alusrc_in, regdst_in, aluop_in, pcsumain_in, data1_in, data2_in,
             signextender_in, rs_in, rt_in, rd_in,
      output regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out, alusrc_out,
             regdst_out, aluop_out, pcsumain_out, data1_out, data2_out, signextender_out,
             rs_out, rt_out, rd_out, valid_out, load_use_hazard_out, bubble_cnt_out, stall_cnt_out
   );
`else
   modport master (
      output stall_in, flush_in, valid_in, regwrite_in, memtoreg_in, memwrite_in, memread_in,
             branch_in, alusrc_in, regdst_in, aluop_in, pcsumain_in, data1_in, data2_in,
             signextender_in, rs_in, rt_in, rd_in,
      input  regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out, alusrc_out,
             regdst_out, aluop_out, pcsumain_out, data1_out, data2_out, signextender_out,
             rs_out, rt_out, rd_out, valid_out, load_use_hazard_out
   );
   modport slave (
      input  stall_in, flush_in, valid_in, regwrite_in, memtoreg_in, memwrite_in, memread_in,
             branch_in, alusrc_in, regdst_in, aluop_in, pcsumain_in, data1_in, data2_in,
             signextender_in, rs_in, rt_in, rd_in,
      output regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out, alusrc_out,
             regdst_out, aluop_out, pcsumain_out, data1_out, data2_out, signextender_out,
             rs_out, rt_out, rd_out, valid_out, load_use_hazard_out
   );
`endif
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with stall, flush (bubble), valid bit and load-use hazard detect.
// Define IDEX_PERF_CNT_EN to add saturating bubble/stall counters.
module idex_pipe_reg #(
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int ALUOP_W   = 3
) (
   input logic   clk,
   input logic   rst,
   idex_if.slave bus
);
   logic                 r_regwrite, r_memtoreg, r_memwrite, r_memread, r_branch;
   logic                 r_alusrc, r_regdst, r_valid;
   logic [ALUOP_W-1:0]   r_aluop;
   logic [DATA_W-1:0]    r_pcsumain, r_data1, r_data2, r_signextender;
   logic [REGADDR_W-1:0] r_rs, r_rt, r_rd;
   logic                 w_hazard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_regwrite     <= 1'b0;
         r_memtoreg     <= 1'b0;
         r_memwrite     <= 1'b0;
         r_memread      <= 1'b0;
         r_branch       <= 1'b0;
         r_alusrc       <= 1'b0;
         r_regdst       <= 1'b0;
         r_valid        <= 1'b0;
         r_aluop        <= '0;
         r_pcsumain     <= '0;
         r_data1        <= '0;
         r_data2        <= '0;
         r_signextender <= '0;
         r_rs           <= '0;
         r_rt           <= '0;
         r_rd           <= '0;
      end else if (bus.flush_in) begin
         // Bubble: kill only the side-effect controls; operand fields keep their stale values.
         r_regwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_memwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_branch   <= 1'b0;
         r_valid    <= 1'b0;
      end else if (!bus.stall_in) begin
         r_regwrite     <= bus.regwrite_in & bus.valid_in;
         r_memtoreg     <= bus.memtoreg_in & bus.valid_in;
         r_memwrite     <= bus.memwrite_in & bus.valid_in;
         r_memread      <= bus.memread_in  & bus.valid_in;
         r_branch       <= bus.branch_in   & bus.valid_in;
         r_alusrc       <= bus.alusrc_in;
         r_regdst       <= bus.regdst_in;
         r_valid        <= bus.valid_in;
         r_aluop        <= bus.aluop_in;
         r_pcsumain     <= bus.pcsumain_in;
         r_data1        <= bus.data1_in;
         r_data2        <= bus.data2_in;
         r_signextender <= bus.signextender_in;
         r_rs           <= bus.rs_in;
         r_rt           <= bus.rt_in;
         r_rd           <= bus.rd_in;
      end
   end

   // $zero is never a true dependency, so rt==0 cannot raise a hazard.
   assign w_hazard = r_valid & r_memread & (r_rt != '0) &
                     ((r_rt == bus.rs_in) | (r_rt == bus.rt_in));

   assign bus.regwrite_out        = r_regwrite;
   assign bus.memtoreg_out        = r_memtoreg;
   assign bus.memwrite_out        = r_memwrite;
   assign bus.memread_out         = r_memread;
   assign bus.branch_out          = r_branch;
   assign bus.alusrc_out          = r_alusrc;
   assign bus.regdst_out          = r_regdst;
   assign bus.aluop_out           = r_aluop;
   assign bus.pcsumain_out        = r_pcsumain;
   assign bus.data1_out           = r_data1;
   assign bus.data2_out           = r_data2;
   assign bus.signextender_out    = r_signextender;
   assign bus.rs_out              = r_rs;
   assign bus.rt_out              = r_rt;
   assign bus.rd_out              = r_rd;
   assign bus.valid_out           = r_valid;
   assign bus.load_use_hazard_out = w_hazard;

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] r_bubble_cnt, r_stall_cnt;
   logic        w_bubble_evt, w_stall_evt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign w_bubble_evt = bus.flush_in | (!bus.stall_in & !bus.valid_in);
   assign w_stall_evt  = bus.stall_in & !bus.flush_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_bubble_evt) r_bubble_cnt <= sat_inc(r_bubble_cnt);
         if (w_stall_evt)  r_stall_cnt  <= sat_inc(r_stall_cnt);
      end
   end

   assign bus.bubble_cnt_out = r_bubble_cnt;
   assign bus.stall_cnt_out  = r_stall_cnt;
`endif
endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomised + directed bench for idex_pipe_reg against a transaction-level model.
module tb_idex_pipe_reg;
   localparam int DATA_W = 32, REGADDR_W = 5, ALUOP_W = 3;

   typedef struct packed {
      logic regwrite, memtoreg, memwrite, memread, branch, alusrc, regdst;
      logic [ALUOP_W-1:0]   aluop;
      logic [DATA_W-1:0]    pc, d1, d2, se;
      logic [REGADDR_W-1:0] rs, rt, rd;
      logic                 valid;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall = 1'b0, flush = 1'b0;
   st_t  cur = '0;
   st_t  m   = '0;
   st_t  dut_o;
   int   n_chk = 0, n_pass = 0;
   int unsigned bub_m = 0, stl_m = 0;

   idex_if #(.DATA_W(DATA_W), .REGADDR_W(REGADDR_W), .ALUOP_W(ALUOP_W)) bus ();
   idex_pipe_reg #(.DATA_W(DATA_W), .REGADDR_W(REGADDR_W), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.stall_in = stall;
   assign bus.flush_in = flush;
   assign bus.valid_in = cur.valid;
   assign bus.regwrite_in = cur.regwrite;
   assign bus.memtoreg_in = cur.memtoreg;
   assign bus.memwrite_in = cur.memwrite;
   assign bus.memread_in  = cur.memread;
   assign bus.branch_in   = cur.branch;
   assign bus.alusrc_in   = cur.alusrc;
   assign bus.regdst_in   = cur.regdst;
   assign bus.aluop_in    = cur.aluop;
   assign bus.pcsumain_in = cur.pc;
   assign bus.data1_in    = cur.d1;
   assign bus.data2_in    = cur.d2;
   assign bus.signextender_in = cur.se;
   assign bus.rs_in = cur.rs;
   assign bus.rt_in = cur.rt;
   assign bus.rd_in = cur.rd;

   assign dut_o = {bus.regwrite_out, bus.memtoreg_out, bus.memwrite_out, bus.memread_out,
                   bus.branch_out, bus.alusrc_out, bus.regdst_out, bus.aluop_out,
                   bus.pcsumain_out, bus.data1_out, bus.data2_out, bus.signextender_out,
                   bus.rs_out, bus.rt_out, bus.rd_out, bus.valid_out};

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int unsigned sat(input int unsigned v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   // What EX must hold after an edge, given what it held and what ID offered.
   function automatic st_t next_ex(input st_t prev, input st_t id, input logic stl, input logic fl);
      st_t n;
      if (fl) begin
         n = prev;
         {n.regwrite, n.memtoreg, n.memwrite, n.memread, n.branch, n.valid} = '0;
      end else if (stl) begin
         n = prev;
      end else begin
         n = id;
         if (!id.valid) {n.regwrite, n.memtoreg, n.memwrite, n.memread, n.branch} = '0;
      end
      return n;
   endfunction

   function automatic logic exp_hazard(input st_t ex, input st_t id);
      return ex.valid && ex.memread && ex.rt != 0 && (ex.rt == id.rs || ex.rt == id.rt);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m <= '0; bub_m <= 0; stl_m <= 0;
      end else begin
         m <= next_ex(m, cur, stall, flush);
         if (flush || (!stall && !cur.valid)) bub_m <= sat(bub_m);
         if (stall && !flush) stl_m <= sat(stl_m);
      end
   end

   always @(negedge clk) begin
      check("outputs", dut_o, m);
      check("hazard", bus.load_use_hazard_out, exp_hazard(m, cur));
`ifdef IDEX_PERF_CNT_EN
      check("bubble_cnt", bus.bubble_cnt_out, bub_m);
      check("stall_cnt", bus.stall_cnt_out, stl_m);
`endif
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [159:0] tmp;
      cur = '1;
      #1 rst = 1'b1;
      #1 check("rst_all_zero", dut_o, '0);
      repeat (2) step();
      check("rst_held_zero", dut_o, '0);
      rst = 1'b0;
      step();
      check("post_rst_data1", bus.data1_out, 32'hFFFF_FFFF);
      check("post_rst_rd", bus.rd_out, 5'h1F);
      check("post_rst_valid", bus.valid_out, 1'b1);

      for (int i = 0; i < 4; i++) begin
         cur = '0;
         cur.pc = 32'(4 * (i + 1)); cur.d1 = 32'h1000 + 32'(i); cur.d2 = 32'h2000 + 32'(i);
         cur.rt = 5'd9; cur.rd = 5'd17; cur.valid = 1'b1; cur.regwrite = 1'b1;
         step();
         check("pipe_pc", bus.pcsumain_out, 32'(4 * (i + 1)));
         check("pipe_d2", bus.data2_out, 32'h2000 + 32'(i));
         check("pipe_rt_rd", {bus.rt_out, bus.rd_out}, {5'd9, 5'd17});
      end

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cur.pc = $urandom; cur.d1 = $urandom;
         step();
         check("stall_pc", bus.pcsumain_out, 32'h10);
         check("stall_d1", bus.data1_out, 32'h1003);
      end
      stall = 1'b0; cur.pc = 32'h14;
      step();
      check("release_pc", bus.pcsumain_out, 32'h14);

      cur = '0; cur.regwrite = 1'b1; cur.memwrite = 1'b1; cur.d1 = 32'hDEAD_BEEF; cur.valid = 1'b1;
      step();
      stall = 1'b1; flush = 1'b1; cur.d1 = 32'h0;
      step();
      check("flush_ctl", {bus.regwrite_out, bus.memwrite_out, bus.valid_out}, 3'b000);
      check("flush_d1", bus.data1_out, 32'hDEAD_BEEF);
      stall = 1'b0; flush = 1'b0;

      cur = '0; cur.memread = 1'b1; cur.rt = 5'd8; cur.rs = 5'd1; cur.valid = 1'b1;
      step();
      stall = 1'b1; cur.rs = 5'd8; cur.rt = 5'd2;
      #1 check("lu_rs_match", bus.load_use_hazard_out, 1'b1);
      cur.rs = 5'd3; cur.rt = 5'd3;
      #1 check("lu_no_match", bus.load_use_hazard_out, 1'b0);
      stall = 1'b0; cur.rt = 5'd0; cur.rs = 5'd0;
      step();
      check("lu_rt_zero", bus.load_use_hazard_out, 1'b0);

`ifdef IDEX_PERF_CNT_EN
      rst = 1'b1;
      #2 rst = 1'b0;
      cur.valid = 1'b1;
      flush = 1'b1; step(); step();
      flush = 1'b0; stall = 1'b1; step(); step(); step();
      stall = 1'b0; cur.valid = 1'b0; step();
      cur.valid = 1'b1; step(); step();
      check("cnt_bubble", bus.bubble_cnt_out, 32'd3);
      check("cnt_stall", bus.stall_cnt_out, 32'd3);
      stall = 1'b1; step();
      rst = 1'b1;
      #1 check("cnt_async_clr", {bus.bubble_cnt_out, bus.stall_cnt_out}, 64'd0);
      #1 rst = 1'b0; stall = 1'b0;
`endif

      for (int i = 0; i < 400; i++) begin
         tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cur = st_t'(tmp[$bits(st_t)-1:0]);
         cur.rs = 5'($urandom_range(0, 3));
         cur.rt = 5'($urandom_range(0, 3));
         cur.valid = ($urandom_range(0, 4) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 6) == 0);
         if (i == 200) begin
            rst = 1'b1;
            #1 check("rand_async_rst", dut_o, '0);
            rst = 1'b0;
         end
         step();
      end
      stall = 1'b0; flush = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
